// File: rtl/alert_rx_if.sv
// rtl/alert_rx_if.sv - differential alert receiver bundle shared by the array and its senders
interface alert_rx_if #(
  parameter int NUM_ALERTS = 4
);
  logic [NUM_ALERTS-1:0] alert_p_i;
  logic [NUM_ALERTS-1:0] alert_n_i;
  logic [NUM_ALERTS-1:0] ping_req_i;
  logic [NUM_ALERTS-1:0] ack_p_o;
  logic [NUM_ALERTS-1:0] ack_n_o;
  logic [NUM_ALERTS-1:0] ping_p_o;
  logic [NUM_ALERTS-1:0] ping_n_o;
  logic [NUM_ALERTS-1:0] alert_o;
  logic [NUM_ALERTS-1:0] ping_ok_o;
  logic [NUM_ALERTS-1:0] integ_fail_o;
  logic [NUM_ALERTS-1:0] ping_timeout_o;

  // receiver side (alert_rx_array)
  modport slave (
    input  alert_p_i, alert_n_i, ping_req_i,
    output ack_p_o, ack_n_o, ping_p_o, ping_n_o,
    output alert_o, ping_ok_o, integ_fail_o, ping_timeout_o
  );

  // sender / environment side
  modport master (
    output alert_p_i, alert_n_i, ping_req_i,
    input  ack_p_o, ack_n_o, ping_p_o, ping_n_o,
    input  alert_o, ping_ok_o, integ_fail_o, ping_timeout_o
  );
endinterface

// File: rtl/alert_rx_array.sv
// rtl/alert_rx_array.sv - array of differential alert receivers with ping; ALERT_RX_PING_TIMEOUT_EN adds ping timeouts
module alert_rx_array #(
  parameter int NUM_ALERTS   = 4,
  parameter int PING_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  alert_rx_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [NUM_ALERTS-1:0] alert_p_q;
  logic [NUM_ALERTS-1:0] alert_n_q;
  logic [NUM_ALERTS-1:0] pend_q;
  logic [NUM_ALERTS-1:0] ping_q;
  logic [1:0]            state_q [NUM_ALERTS];

  logic [NUM_ALERTS-1:0] fail;
  logic [NUM_ALERTS-1:0] rise;
  logic [NUM_ALERTS-1:0] fall;
  logic [NUM_ALERTS-1:0] alert_ev;
  logic [NUM_ALERTS-1:0] ok_ev;
  logic [NUM_ALERTS-1:0] to_ev;
  logic [NUM_ALERTS-1:0] ping_issue;
  logic [NUM_ALERTS-1:0] ack_p;

  // single input register stage; every decision below uses this registered pair
  always_ff @(posedge clk) begin
    if (rst) begin
      alert_p_q <= '0;
      alert_n_q <= '1;
    end else begin
      alert_p_q <= bus.alert_p_i;
      alert_n_q <= bus.alert_n_i;
    end
  end

  for (genvar i = 0; i < NUM_ALERTS; i++) begin : g_ch
    assign fail[i] = (alert_p_q[i] == alert_n_q[i]);
    assign rise[i] = alert_p_q[i] & ~alert_n_q[i];
    assign fall[i] = ~alert_p_q[i] & alert_n_q[i];

    // a detected assertion is a ping answer when a ping is outstanding, otherwise a real alert
    assign alert_ev[i]   = ~rst & (state_q[i] == ST_IDLE) & rise[i] & ~pend_q[i];
    assign ok_ev[i]      = ~rst & (state_q[i] == ST_IDLE) & rise[i] & pend_q[i];
    assign ping_issue[i] = bus.ping_req_i[i] & ~pend_q[i];

    // ack is dropped immediately on an integrity failure, not one cycle later
    assign ack_p[i] = (state_q[i] == ST_ACK) & ~fail[i];

    // per-channel handshake FSM; an integrity failure forces IDLE from any state
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q[i] <= ST_IDLE;
      end else if (fail[i]) begin
        state_q[i] <= ST_IDLE;
      end else begin
        case (state_q[i])
          ST_IDLE: if (rise[i]) state_q[i] <= ST_ACK;
          ST_ACK:  if (fall[i]) state_q[i] <= ST_DONE;
          ST_DONE: state_q[i] <= ST_IDLE;
          default: state_q[i] <= ST_IDLE;
        endcase
      end
    end

    // level-toggle ping; requests arriving while a ping is outstanding are dropped
    always_ff @(posedge clk) begin
      if (rst) begin
        ping_q[i] <= 1'b0;
        pend_q[i] <= 1'b0;
      end else if (ping_issue[i]) begin
        ping_q[i] <= ~ping_q[i];
        pend_q[i] <= 1'b1;
      end else if (ok_ev[i] | to_ev[i]) begin
        pend_q[i] <= 1'b0;
      end
    end

`ifdef ALERT_RX_PING_TIMEOUT_EN
    logic [16:0] cnt_q;

    // counts cycles since ping issue; an answer on the expiry cycle wins over the timeout
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (ping_issue[i]) begin
        cnt_q <= '0;
      end else if (pend_q[i] & ~ok_ev[i] & ~to_ev[i]) begin
        cnt_q <= cnt_q + 17'd1;
      end
    end

    assign to_ev[i] = ~rst & pend_q[i] & (cnt_q == 17'(PING_TIMEOUT)) & ~ok_ev[i];
`else
    assign to_ev[i] = 1'b0;
`endif
  end

  assign bus.ack_p_o        = ack_p;
  assign bus.ack_n_o        = ~ack_p;
  assign bus.ping_p_o       = ping_q;
  assign bus.ping_n_o       = ~ping_q;
  assign bus.alert_o        = alert_ev;
  assign bus.ping_ok_o      = ok_ev;
  assign bus.integ_fail_o   = fail & {NUM_ALERTS{~rst}};
  assign bus.ping_timeout_o = to_ev;

endmodule
